// File: rtl/reg_shift_seq.sv
// Serial shift/rotate unit: loads an operand, then moves it one bit per clock.
// Handshake is START in, BUSY while shifting, and a one-cycle DONE pulse.
module reg_shift_seq #(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [2:0]     OP,
  input  logic [SHW-1:0] SHAMT,
  input  logic [W-1:0]   INP,
  output logic [W-1:0]   OUT,
  output logic           BUSY,
  output logic           DONE,
  output logic           CO,
  output logic           Z
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;

  state_t         state_q;
  logic [2:0]     op_q;
  logic [SHW-1:0] cnt_q;
  logic [W-1:0]   out_q;
  logic           co_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   sh_d;
  logic           co_d;
  logic           is_sh;
  logic           acc;

  // One-bit step of the captured operation.
  always_comb begin
    sh_d = out_q;
    co_d = co_q;
    case (op_q)
      OP_LSL: begin
        sh_d = {out_q[W-2:0], 1'b0};
        co_d = out_q[W-1];
      end
      OP_LSR: begin
        sh_d = {1'b0, out_q[W-1:1]};
        co_d = out_q[0];
      end
      OP_ASR: begin
        sh_d = {out_q[W-1], out_q[W-1:1]};
        co_d = out_q[0];
      end
      OP_ROR: begin
        sh_d = {out_q[0], out_q[W-1:1]};
        co_d = out_q[0];
      end
      OP_ROL: begin
        sh_d = {out_q[W-2:0], out_q[W-1]};
        co_d = out_q[W-1];
      end
      default: begin
        sh_d = out_q;
        co_d = co_q;
      end
    endcase
  end

  assign is_sh = (OP >= OP_LSL) && (OP <= OP_ROL);
  assign acc   = START && (state_q != S_SHIFT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_LD;
      cnt_q   <= '0;
      out_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          out_q <= sh_d;
          co_q  <= co_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (acc) begin
            op_q <= OP;
            co_q <= 1'b0;
            if (OP == OP_CLR) begin
              out_q   <= '0;
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (is_sh && (SHAMT != '0)) begin
              out_q   <= INP;
              cnt_q   <= SHAMT;
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Load, reserved code, or a zero-length shift.
              out_q   <= INP;
              cnt_q   <= SHAMT;
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign OUT  = out_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign CO   = co_q;
  assign Z    = (out_q == '0);

endmodule

// File: tb/tb_reg_shift_seq.sv
// Bench for reg_shift_seq at W=8: directed cases plus random ops,
// scored against an arithmetic model through an expectation queue.
module tb_reg_shift_seq;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic [2:0]     OP;
  logic [SHW-1:0] SHAMT;
  logic [W-1:0]   INP;
  logic [W-1:0]   OUT;
  logic           BUSY;
  logic           DONE;
  logic           CO;
  logic           Z;

  typedef struct {
    logic [W-1:0] out;
    logic         co;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  reg_shift_seq #(.W(W), .SHW(SHW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .SHAMT (SHAMT),
    .INP   (INP),
    .OUT   (OUT),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .CO    (CO),
    .Z     (Z)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: whole-operation result from plain arithmetic.
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] inp,
                                 input int n);
    exp_t e;
    int unsigned v;
    int s;
    int unsigned r;
    v = inp;
    s = int'($signed(inp));
    r = v;
    e.co = 1'b0;
    case (op)
      3'd1: begin
        r = (v << n) & 255;
        if (n > 0) e.co = 1'((v >> (W - n)) & 1);
      end
      3'd2: begin
        r = v >> n;
        if (n > 0) e.co = 1'((v >> (n - 1)) & 1);
      end
      3'd3: begin
        r = int'(s >>> n) & 255;
        if (n > 0) e.co = 1'((v >> (n - 1)) & 1);
      end
      3'd4: begin
        r = ((v >> n) | (v << (W - n))) & 255;
        if (n > 0) e.co = 1'((r >> (W - 1)) & 1);
      end
      3'd5: begin
        r = ((v << n) | (v >> (W - n))) & 255;
        if (n > 0) e.co = 1'(r & 1);
      end
      3'd6: r = 0;
      default: r = v;
    endcase
    e.out = W'(r);
    e.done_cyc = 0;
    return e;
  endfunction

  function automatic int eff_n(input logic [2:0] op, input int n);
    return (op >= 3'd1 && op <= 3'd5) ? n : 0;
  endfunction

  // Monitor: every DONE pulse must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && DONE) begin
      chk("busy_with_done", int'(BUSY), 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DONE required none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("out", int'(OUT), int'(e.out));
        chk("co", int'(CO), int'(e.co));
        chk("z", int'(Z), int'(e.out == 0));
        chk("latency", cyc, e.done_cyc);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [W-1:0] inp,
                       input int n);
    exp_t e;
    START = 1'b1;
    OP    = op;
    INP   = inp;
    SHAMT = SHW'(n);
    e = model(op, inp, eff_n(op, n));
    e.done_cyc = cyc + 1 + eff_n(op, n);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int n, input bit junk);
    int  bn;
    bit  seen;
    bn   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) bn++;
      START = BUSY && (junk || ($urandom % 3 == 0));
      OP    = 3'($urandom);
      INP   = W'($urandom);
      SHAMT = SHW'($urandom);
    end
    START = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("busy_cycles", bn, n);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] inp,
                       input int n, input bit junk);
    drive(op, inp, n);
    wait_done(eff_n(op, n), junk);
  endtask

  task automatic idle(input int k);
    START = 1'b0;
    repeat (k) @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST   = 1'b0;
    START = 1'b0;
    OP    = '0;
    SHAMT = '0;
    INP   = '0;
    #2 RST = 1'b1;
    #1;
    chk("rst_out", int'(OUT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_co", int'(CO), 0);
    chk("rst_z", int'(Z), 1);
    START = 1'b1;
    OP    = 3'd0;
    INP   = 8'hA5;
    repeat (3) @(negedge CLK);
    chk("start_in_rst", int'(OUT), 0);
    START = 1'b0;
    RST   = 1'b0;

    issue(3'd1, 8'h81, 1, 1'b0);
    issue(3'd3, 8'h80, 3, 1'b0);
    idle(1);
    issue(3'd4, 8'h01, 1, 1'b0);
    issue(3'd5, 8'h80, 1, 1'b0);
    idle(2);
    issue(3'd2, 8'h5A, 0, 1'b0);
    issue(3'd6, 8'hC3, 5, 1'b0);
    chk("clear_z", int'(Z), 1);
    issue(3'd7, 8'h3C, 4, 1'b0);
    idle(1);
    issue(3'd1, 8'h01, 7, 1'b1);
    idle(2);

    drive(3'd1, 8'h0F, 7);
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_out", int'(OUT), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_co", int'(CO), 0);
    chk("abort_z", int'(Z), 1);
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    idle(12);
    chk("abort_hold", int'(OUT), 0);

    for (int k = 0; k < 200; k++) begin
      issue(3'($urandom), W'($urandom), int'($urandom_range(0, 7)),
            1'($urandom));
      if ($urandom % 2 == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(3);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_shift_seq.md
REG_SHIFT_SEQ -- requirements
Module: reg_shift_seq

Interface
REQ-001 The block SHALL have the following parameters:
- W, 32, data width, at least 2.
- SHW, $clog2(W), shift-amount width.
REQ-002 The block SHALL have the following ports, clock and reset first:
- CLK  input  1  single clock; all state changes on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  operation request, sampled on the CLK rising edge.
- OP  input  3  operation code (REQ-005).
- SHAMT  input  SHW  shift or rotate amount.
- INP  input  W  operand.
- OUT  output  W  result register.
- BUSY  output  1  high while shifting is in progress.
- DONE  output  1  single-cycle completion pulse.
- CO  output  1  last bit shifted or rotated out.
- Z  output  1  high when OUT is all zeros.

Function
REQ-003 The block SHALL implement three states: IDLE, SHIFT and FIN. All outputs except Z SHALL be registered.
REQ-004 START SHALL be accepted only in IDLE or FIN. START in SHIFT SHALL be ignored, with no change to state, OUT, count or CO.
REQ-005 OP encoding SHALL be:
- 000 load
- 001 logical shift left (LSL), zero in at bit 0
- 010 logical shift right (LSR), zero in at bit W-1
- 011 arithmetic shift right (ASR), bit W-1 replicated
- 100 rotate right (ROR)
- 101 rotate left (ROL)
- 110 clear
- 111 reserved, executed as load
REQ-006 On an accepted START, the block SHALL capture OP internally and clear CO to 0.
- For load: OUT <= INP.
- For clear: OUT <= 0.
- For a shift or rotate: OUT <= INP and the internal counter <= SHAMT.
REQ-007 After an accepted START, the next state SHALL be:
- FIN for load, clear, or any shift or rotate with SHAMT = 0.
- SHIFT otherwise.
REQ-008 In SHIFT, each edge SHALL do three things:
- shift or rotate OUT by exactly one bit in the captured direction;
- load CO with the bit leaving the register (bit W-1 for LSL/ROL, bit 0 for LSR/ASR/ROR);
- decrement the counter.
The state SHALL become FIN on the edge where the counter goes from 1 to 0.
REQ-009 Latency: DONE SHALL be high in the cycle following the accepted-START edge plus SHAMT shift edges, i.e. SHAMT+1 edges after START. Load and clear SHALL take 1 edge.
REQ-010 DONE SHALL be high only in FIN, for exactly one cycle. BUSY SHALL be high only in SHIFT. DONE and BUSY SHALL never be high together.
REQ-011 From FIN, the next state SHALL be IDLE, unless START is high, in which case REQ-006/REQ-007 apply (back-to-back operation with no idle cycle).
REQ-012 OUT and CO SHALL hold their values in IDLE and FIN until the next accepted START.
REQ-013 Z SHALL be combinational: Z = (OUT == 0).
REQ-014 SHAMT SHALL be treated as unsigned. SHAMT values of W or more (possible when W is not a power of 2) SHALL be executed as full serial shifts with no saturation.
REQ-015 Changes on INP, OP or SHAMT after the START edge SHALL NOT affect an operation in progress.

Reset
REQ-016 RST high SHALL immediately, without waiting for CLK, force:
- state = IDLE
- OUT = 0
- counter = 0
- CO = 0
- BUSY = 0
- DONE = 0
As a result, Z = 1.
REQ-017 RST asserted during SHIFT SHALL abort the operation, with no DONE pulse.
REQ-018 START SHALL be ignored while RST is high. The first START SHALL be honoured on the first rising edge after RST deasserts.

Verification (W = 8)
REQ-019 LSL: START, OP=001, INP=0x81, SHAMT=1 -> BUSY high for 1 cycle, then DONE high with OUT=0x02, CO=1, Z=0.
REQ-020 ASR: START, OP=011, INP=0x80, SHAMT=3 -> BUSY high for 3 cycles, then DONE with OUT=0xF0, CO=0.
REQ-021 ROR: START, OP=100, INP=0x01, SHAMT=1 -> OUT=0x80, CO=1. Back-to-back START in FIN with OP=101, SHAMT=1 -> OUT=0x01, CO=1, with no IDLE cycle between the two DONE pulses.
REQ-022 Zero amount and clear:
- START, OP=010, INP=0x5A, SHAMT=0 -> DONE on the next cycle, OUT=0x5A, BUSY never high.
- START, OP=110 -> OUT=0x00, Z=1.
REQ-023 START while busy: START, OP=001, SHAMT=7; a second START with INP=0xFF during SHIFT -> second START ignored, DONE exactly once, after 8 edges.
REQ-024 Reset mid-operation: RST pulsed mid-SHIFT between clock edges -> OUT=0, BUSY=0, DONE=0, CO=0 immediately, with no DONE pulse afterward.
